// File: rtl/mem_pkg.sv
// Shared definitions for the byte-lane Wishbone memory: FSM encodings and sizing helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mem_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Two-bit tile repeated across the word to form the default sweep value.
    localparam logic [1:0] INIT_PATTERN = 2'b10;

    // Wait-state counter covers 0..15 extra cycles.
    localparam int WAIT_CNT_W = 4;

    // Words of DATA_WIDTH bits in a memory of mem_size_kb kilobytes.
    function automatic int mem_depth(input int data_width, input int mem_size_kb);
        return (mem_size_kb * 1024 * 8) / data_width;
    endfunction

    // Ceiling log2, valid for the positive sizes used here.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_be_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Latency: write lands on the enabling edge; read data appears one edge after re.
// Backpressure: none; accepts one access per cycle, caller gates requests.
module mem_be_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]   wdat,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   rdat
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write and registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (be[k]) mem[addr][k*8 +: 8] <= wdat[k*8 +: 8];
            end
        end
        if (re) rdat <= mem[addr];
    end

endmodule

// File: rtl/wb_mem_be.sv
// Wishbone B4 classic memory slave with byte lanes, wait states, range error and init sweep.
// Latency: ack/err one cycle after the request is sampled plus WAIT_STATES; one-cycle response.
// Backpressure: master stalls (no ack/err) during the init sweep and wait states.
module wb_mem_be
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_SIZE    = 64,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    WAIT_STATES = 0,
    parameter bit                    INIT_EN     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = {DATA_WIDTH/2{INIT_PATTERN}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    init_done_o
);

    localparam int MEM_DEPTH = mem_depth(DATA_WIDTH, MEM_SIZE);
    localparam int IDX_W     = (clog2(MEM_DEPTH) > 0) ? clog2(MEM_DEPTH) : 1;
    localparam int SEL_W     = DATA_WIDTH / 8;
    localparam bit HAS_WAIT  = (WAIT_STATES > 0);

    // One extra bit so a depth of exactly 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(MEM_DEPTH - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]        init_cnt_q, init_cnt_d;
    logic                    ack_q, err_q, rd_q, init_done_q;
    logic                    req, in_range, access, init_wr;

    logic                    arr_we, arr_re;
    logic [SEL_W-1:0]        arr_be;
    logic [IDX_W-1:0]        arr_addr;
    logic [DATA_WIDTH-1:0]   arr_wdat, arr_rdat;

    assign req      = wb_cyc_i & wb_stb_i;
    assign in_range = ({1'b0, wb_adr_i} < DEPTH_LIM);

    // Next-state logic; `access` marks the single edge that enters RESP and commits the transfer.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        init_cnt_d = init_cnt_q;
        access     = 1'b0;
        init_wr    = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr    = 1'b1;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    init_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    if (HAS_WAIT) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        access  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    // Master withdrew: abandon without touching memory or responding.
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    access     = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_EN ? ST_INIT : ST_IDLE;
            wait_cnt_q  <= '0;
            init_cnt_q  <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            init_cnt_q  <= init_cnt_d;
            ack_q       <= access & in_range;
            err_q       <= access & ~in_range;
            rd_q        <= access & ~wb_we_i;
            init_done_q <= (state_d != ST_INIT);
        end
    end

    // The sweep owns the array port while in INIT; otherwise the bus does, only on commit.
    // rst_n qualifies the write so a request held through reset can never land.
    assign arr_we   = rst_n & (init_wr | (access & wb_we_i & in_range));
    assign arr_re   = access & ~wb_we_i & in_range;
    assign arr_be   = init_wr ? {SEL_W{1'b1}} : wb_sel_i;
    assign arr_addr = init_wr ? init_cnt_q : wb_adr_i[IDX_W-1:0];
    assign arr_wdat = init_wr ? INIT_VALUE : wb_dat_i;

    mem_be_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .be   (arr_be),
        .addr (arr_addr),
        .wdat (arr_wdat),
        .re   (arr_re),
        .rdat (arr_rdat)
    );

    // Read data is only driven during a read acknowledge; zero otherwise (including errors).
    assign wb_dat_o    = (ack_q & rd_q) ? arr_rdat : '0;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign init_done_o = init_done_q;

endmodule

// File: doc/wb_mem_be.md
# wb_mem_be

Parametrised Wishbone B4 classic slave memory: the next-generation on-chip RAM for the Osiris SoC data/instruction space. Adds byte-lane writes, configurable wait states, out-of-range error signalling, and a post-reset initialisation sweep in place of the single-cycle whole-array reset. It sits directly on the Wishbone interconnect as a memory slave.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8
- MEM_SIZE, 64, capacity in KB; MEM_DEPTH = MEM_SIZE*1024*8/DATA_WIDTH words
- ADDR_WIDTH, 16, word-address bus width; must be ≥ clog2(MEM_DEPTH)
- WAIT_STATES, 0, extra cycles inserted before ack/err (0..15)
- INIT_EN, 1, 1 = run init sweep after reset; 0 = skip
- INIT_VALUE, {DATA_WIDTH/2{2'b10}}, word written by the init sweep
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wb_adr_i  in  ADDR_WIDTH  word address
- wb_dat_i  in  DATA_WIDTH  write data
- wb_sel_i  in  DATA_WIDTH/8  byte-lane write enables
- wb_we_i  in  1  1 = write
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_dat_o  out  DATA_WIDTH  read data, valid only while wb_ack_o=1, else 0
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (address ≥ MEM_DEPTH)
- init_done_o  out  1  high once the init sweep is complete

## Operation
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, init_done_o=0, state=INIT (INIT_EN=1) or IDLE (INIT_EN=0), counters 0. Array contents are not reset.
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT: each cycle writes INIT_VALUE to word init_cnt, increments; after writing word MEM_DEPTH-1 → IDLE, init_done_o=1 from the next cycle on. Bus requests during INIT get no ack/err (master stalls).
- INIT_EN=0: init_done_o rises the first cycle after reset release.
- IDLE: on cyc&stb → WAIT if WAIT_STATES>0 (load wait counter), else RESP.
- WAIT: counts down WAIT_STATES cycles → RESP. cyc or stb low during WAIT → IDLE, no access, no response.
- Entry to RESP (single edge): if address < MEM_DEPTH: write lanes with wb_sel_i[k]=1 (we=1), or register full word into wb_dat_o (we=0), assert wb_ack_o; else assert wb_err_o, no write, wb_dat_o=0.
- RESP lasts exactly one cycle, then IDLE; ack/err deassert. A still-asserted stb in IDLE is a new transfer.
- wb_sel_i ignored on reads; a write with wb_sel_i=0 acks with no change.
- Address compared at full ADDR_WIDTH; no wrap/aliasing.

## Timing
- Request sampled at edge N (in IDLE) → ack/err high during cycle N+1+WAIT_STATES, for one cycle.
- Max throughput: one transfer per 2+WAIT_STATES cycles.
- Write visible to a read issued the cycle after its ack.
- Init sweep: MEM_DEPTH cycles; init_done_o high at cycle MEM_DEPTH+1 after reset release.
- rst_n low at any time (mid-init, mid-WAIT, in RESP): outputs go to reset values immediately; an uncommitted write is dropped; init restarts from word 0.
- wb_ack_o and wb_err_o are never high together.

## Structure
- Shared package/header mem_pkg: FSM state encodings, MEM_DEPTH and clog2 helper, default INIT_VALUE.
- Sub-module mem_be_array: storage with per-byte write enable and registered read port, so an SRAM macro can replace it without touching the FSM.
- Top holds FSM, wait counter, init counter, range check, response muxing.

## Test plan
- MEM_SIZE=1, INIT_EN=1: release reset → init_done_o rises after 256+1 cycles; read addr 0x00 and 0xFF → 0xAAAAAAAA, each acked one cycle after request.
- Write 0xDEADBEEF, sel=4'b1111 to addr 0x10, then write 0x00000011, sel=4'b0001 → read addr 0x10 returns 0xDEADBE11.
- WAIT_STATES=3: read issued edge N → ack only in cycle N+4; drop stb at N+2 on a write → no ack, memory unchanged.
- Address 0x0100 (MEM_SIZE=1) read and write → wb_err_o one cycle, wb_ack_o=0, wb_dat_o=0, array unchanged.
- Request held during INIT → no ack until init done, then acked normally; assert rst_n mid-sweep → init_done_o=0, sweep restarts at word 0.
- Back-to-back reads with stb held high → ack pulses every 2nd cycle, wb_dat_o=0 between acks.
